// File: rtl/pkt_rr_arbiter.sv
// Round-robin arbiter that funnels N tagged 41-bit packet streams into one
// registered valid/ready output, with a running count of accepted transfers.
module pkt_rr_arbiter #(
  parameter int N     = 4,
  parameter int SRC_W = $clog2(N),
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*41-1:0]    in_pkt,
  output logic [N-1:0]       in_ready,
  output logic [40:0]        out_pkt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SRC_W-1:0]   out_src,
  output logic [CNT_W-1:0]   xfer_cnt
);

  localparam int PW = 41;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [SRC_W-1:0] r_rr_ptr;
  logic [SRC_W-1:0] r_src;
  logic [PW-1:0]    r_pkt;
  logic [CNT_W-1:0] r_xfer_cnt;

  logic [N-1:0]     w_req;
  logic             w_found;
  logic [SRC_W-1:0] w_winner;
  logic [SRC_W-1:0] w_ptr_next;
  logic [PW-1:0]    w_win_pkt;
  logic             w_xfer;
  logic             w_can_load;
  logic             w_grant;

  function automatic logic [SRC_W-1:0] rrIndex(input logic [SRC_W-1:0] base, input int k);
    int idx;
    idx = int'(base) + k;
    if (idx >= N) idx = idx - N;
    return SRC_W'(idx);
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_req[i] = in_pkt[i*PW + PW - 1];
    end
  end

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_req[rrIndex(r_rr_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = rrIndex(r_rr_ptr, k);
      end
    end
  end

  assign out_valid  = (r_state == FULL);
  assign w_xfer     = out_valid && out_ready;
  assign w_can_load = (r_state == EMPTY) || w_xfer;
  assign w_grant    = w_can_load && w_found && rst_n;
  assign w_win_pkt  = in_pkt[int'(w_winner)*PW +: PW];
  assign w_ptr_next = (w_winner == SRC_W'(N-1)) ? '0 : w_winner + 1'b1;

  always_comb begin
    in_ready = '0;
    if (w_grant) in_ready[w_winner] = 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_grant) begin
      w_state_next = FULL;
    end else if (w_xfer) begin
      w_state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_rr_ptr   <= '0;
      r_src      <= '0;
      r_pkt      <= '0;
      r_xfer_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_pkt    <= w_win_pkt;
        r_src    <= w_winner;
        r_rr_ptr <= w_ptr_next;
      end
      if (w_xfer) r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end

  assign out_pkt  = r_pkt;
  assign out_src  = r_src;
  assign xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: the stimulus queues expected packets,
// a negedge monitor pops and compares them on every accepted transfer.
module tb_pkt_rr_arbiter;

  localparam int N = 4;

  logic            clk;
  logic            rst_n;
  logic [N*41-1:0] inPkt;
  logic [N-1:0]    inReady;
  logic [40:0]     outPkt;
  logic            outValid;
  logic            outReady;
  logic [1:0]      outSrc;
  logic [15:0]     xferCnt;

  int checks = 0;
  int errors = 0;

  logic [40:0] expPktQ[$];
  logic [1:0]  expSrcQ[$];

  pkt_rr_arbiter #(.N(N), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pkt    (inPkt),
    .in_ready  (inReady),
    .out_pkt   (outPkt),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_src   (outSrc),
    .xfer_cnt  (xferCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [40:0] mkPkt(input logic [7:0] tag, input logic [31:0] data);
    return {1'b1, tag, data};
  endfunction

  task automatic applyStimulus(input int idx, input logic [40:0] pkt);
    inPkt[idx*41 +: 41] = pkt;
  endtask

  task automatic expectGrant(input logic [40:0] pkt, input logic [1:0] src);
    expPktQ.push_back(pkt);
    expSrcQ.push_back(src);
  endtask

  // Scoreboard monitor: a transfer happens at the coming posedge.
  always @(negedge clk) begin
    if (rst_n && outValid && outReady) begin
      if (expPktQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected transfer: got pkt 0x%0h src %0d, expected none", outPkt, outSrc);
      end else begin
        checkOutput("sb out_pkt", 64'(outPkt), 64'(expPktQ.pop_front()));
        checkOutput("sb out_src", 64'(outSrc), 64'(expSrcQ.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [40:0] p;
    logic [40:0] pa;
    logic [40:0] pb;
    int w;

    rst_n    = 1'b0;
    inPkt    = '0;
    outReady = 1'b0;

    // Reset and idle
    #1;
    checkOutput("reset out_valid", 64'(outValid), 0);
    checkOutput("reset in_ready", 64'(inReady), 0);
    repeat (3) nextCycle();
    checkOutput("reset xfer_cnt", 64'(xferCnt), 0);
    checkOutput("reset out_pkt", 64'(outPkt), 0);
    checkOutput("reset out_src", 64'(outSrc), 0);
    rst_n = 1'b1;
    repeat (5) begin
      nextCycle();
      checkOutput("idle out_valid", 64'(outValid), 0);
      checkOutput("idle in_ready", 64'(inReady), 0);
      checkOutput("idle out_pkt", 64'(outPkt), 0);
      checkOutput("idle xfer_cnt", 64'(xferCnt), 0);
    end

    // Single requester 2
    p = 41'h1_A5DE_ADBEEF;
    applyStimulus(2, p);
    outReady = 1'b1;
    #1;
    checkOutput("single in_ready", 64'(inReady), 64'h4);
    expectGrant(p, 2'd2);
    nextCycle();
    applyStimulus(2, '0);
    checkOutput("single out_valid", 64'(outValid), 1);
    checkOutput("single out_pkt", 64'(outPkt), 64'h1_A5DE_ADBEEF);
    checkOutput("single out_src", 64'(outSrc), 2);
    nextCycle();
    checkOutput("single xfer_cnt", 64'(xferCnt), 1);
    checkOutput("single drained", 64'(outValid), 0);

    // Pointer is 3 here; one grant to requester 3 brings it back to 0
    p = mkPkt(8'h33, 32'h3333_3333);
    applyStimulus(3, p);
    #1;
    checkOutput("align in_ready", 64'(inReady), 64'h8);
    expectGrant(p, 2'd3);
    nextCycle();
    applyStimulus(3, '0);
    nextCycle();
    checkOutput("align xfer_cnt", 64'(xferCnt), 2);

    // Round-robin wrap with all four requesting
    for (int i = 0; i < 4; i++) applyStimulus(i, mkPkt(8'(8'h10 + i), 32'hC0DE_0000 + 32'(i)));
    for (int j = 0; j < 6; j++) begin
      w = j % 4;
      #1;
      checkOutput($sformatf("rr grant %0d in_ready", j), 64'(inReady), 64'(4'b0001 << w));
      expectGrant(mkPkt(8'(8'h10 + w), 32'hC0DE_0000 + 32'(w)), 2'(w));
      nextCycle();
    end
    inPkt = '0;
    checkOutput("rr last out_src", 64'(outSrc), 1);
    checkOutput("rr last out_valid", 64'(outValid), 1);
    nextCycle();
    checkOutput("rr drained", 64'(outValid), 0);
    checkOutput("rr xfer_cnt (2 prior + 6)", 64'(xferCnt), 8);

    // Sparse: pointer at 2, only requester 0
    p = mkPkt(8'h5A, 32'h0000_0001);
    applyStimulus(0, p);
    #1;
    checkOutput("skip in_ready", 64'(inReady), 64'h1);
    expectGrant(p, 2'd0);
    nextCycle();
    applyStimulus(0, '0);
    checkOutput("skip out_src", 64'(outSrc), 0);
    checkOutput("skip rr_ptr", 64'(dut.r_rr_ptr), 1);
    nextCycle();
    checkOutput("full to empty out_valid", 64'(outValid), 0);
    checkOutput("full to empty in_ready", 64'(inReady), 0);

    // Backpressure with requesters 1 and 3
    outReady = 1'b0;
    pa = mkPkt(8'hB1, 32'h1111_1111);
    pb = mkPkt(8'hB3, 32'h3333_0003);
    applyStimulus(1, pa);
    applyStimulus(3, pb);
    #1;
    checkOutput("bp first in_ready", 64'(inReady), 64'h2);
    expectGrant(pa, 2'd1);
    nextCycle();
    applyStimulus(1, '0);
    repeat (4) begin
      #1;
      checkOutput("bp stall in_ready", 64'(inReady), 0);
      checkOutput("bp stall out_pkt", 64'(outPkt), 64'(pa));
      checkOutput("bp stall out_src", 64'(outSrc), 1);
      checkOutput("bp stall out_valid", 64'(outValid), 1);
      nextCycle();
    end
    outReady = 1'b1;
    #1;
    checkOutput("bp drain in_ready", 64'(inReady), 64'h8);
    expectGrant(pb, 2'd3);
    nextCycle();
    applyStimulus(3, '0);
    checkOutput("bp reload out_src", 64'(outSrc), 3);
    checkOutput("bp reload out_pkt", 64'(outPkt), 64'(pb));
    nextCycle();
    checkOutput("bp drained", 64'(outValid), 0);
    checkOutput("bp xfer_cnt", 64'(xferCnt), 11);

    // Async reset while holding a packet; the held packet is never transferred
    outReady = 1'b0;
    applyStimulus(2, mkPkt(8'hC2, 32'h2222_2222));
    nextCycle();
    applyStimulus(2, '0);
    applyStimulus(1, pa);
    applyStimulus(3, pb);
    nextCycle();
    checkOutput("pre-reset out_valid", 64'(outValid), 1);
    checkOutput("pre-reset in_ready", 64'(inReady), 0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", 64'(outValid), 0);
    checkOutput("async reset xfer_cnt", 64'(xferCnt), 0);
    checkOutput("async reset in_ready", 64'(inReady), 0);
    checkOutput("async reset out_pkt", 64'(outPkt), 0);
    nextCycle();
    rst_n    = 1'b1;
    outReady = 1'b1;
    #1;
    checkOutput("post-reset in_ready", 64'(inReady), 64'h2);
    expectGrant(pa, 2'd1);
    nextCycle();
    applyStimulus(1, '0);
    #1;
    checkOutput("post-reset second in_ready", 64'(inReady), 64'h8);
    expectGrant(pb, 2'd3);
    nextCycle();
    applyStimulus(3, '0);
    nextCycle();
    checkOutput("post-reset drained", 64'(outValid), 0);
    checkOutput("post-reset xfer_cnt", 64'(xferCnt), 2);

    checkOutput("scoreboard leftover", 64'(expPktQ.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
- Shares one downstream channel of 41-bit packed packets among N requesters using round-robin arbitration.
- Packet layout: bit 40 = valid, bits 39:32 = tag, bits 31:0 = data.
- The winning packet is captured into a single output register and held until the consumer accepts it with a valid/ready handshake.
- Sits between packet producers (e.g. tagged request sources) and a single shared consumer.

Parameters:
- N, 4, number of requesters (2..8).
- SRC_W, $clog2(N), width of the source-id output (derived; do not override).
- CNT_W, 16, width of the accepted-transfer counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_pkt  in  N*41  requester packets; slice i = in_pkt[i*41 +: 41]; bit 40 of each slice is that requester's request.
- in_ready  out  N  one-hot; bit i high = slice i is captured at this clock edge.
- out_pkt  out  41  registered winning packet.
- out_valid  out  1  out_pkt holds a packet.
- out_ready  in  1  consumer accepts out_pkt when out_valid && out_ready.
- out_src  out  SRC_W  index of the requester whose packet is in out_pkt.
- xfer_cnt  out  CNT_W  count of accepted output transfers.

Behaviour:
- Reset values, applied asynchronously while rst_n = 0: out_valid=0, out_pkt=0, out_src=0, xfer_cnt=0, rr_ptr=0, state=EMPTY.
- in_ready is combinational and is 0 while rst_n = 0.
- Request: req[i] = in_pkt slice i, bit 40. Tag and data are don't-care when req[i] = 0.
- States:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- can_load = (state==EMPTY) || (out_valid && out_ready).
- Grant: if can_load and any req, the winner is the first i with req[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod N.
  - in_ready = onehot(winner) in that same cycle; otherwise in_ready = 0.
  - in_ready never has more than one bit set.
- Capture at the clock edge when a grant occurs:
  - out_pkt <= winning slice.
  - out_src <= winner.
  - rr_ptr <= (winner+1) mod N (wraps from N-1 to 0).
  - state <= FULL.
- Transitions:
  - EMPTY, no req: stay EMPTY.
  - EMPTY, req present: grant and capture, go to FULL.
  - FULL, !out_ready: hold. out_pkt, out_src and rr_ptr are stable, in_ready = 0.
  - FULL, out_ready with a new req: drain and reload in the same cycle, stay FULL. Back-to-back throughput is 1 packet/cycle.
  - FULL, out_ready with no req: go to EMPTY. out_pkt keeps its last value (don't-care).
- Latency: a request granted at edge k appears with out_valid=1 after edge k. If the register is empty, in_ready is high in the same cycle req is first seen.
- Requester contract: hold the slice stable with bit 40 = 1 until in_ready[i]. Dropping a request before it is granted is allowed; that requester simply loses the grant.
- rr_ptr moves only on a grant, never on idle cycles.
- Fairness: with all N requesting continuously, each is granted exactly once in every N consecutive grants.
- xfer_cnt increments by 1 on every out_valid && out_ready edge and wraps from 2^CNT_W-1 to 0.
- out_ready while out_valid=0 has no effect.
- A reset mid-operation discards the held packet; no transfer is reported for it.
- A captured packet always has bit 40 = 1.

Test Plan:
- Reset/idle:
  - Stimulus: rst_n=0 for 3 cycles, then release with all req=0 for 5 cycles.
  - Required: out_valid=0, in_ready=0, xfer_cnt=0, out_pkt=0 throughout.
- Single requester:
  - Stimulus: req2 slice = {1, 8'hA5, 32'hDEADBEEF}, out_ready=1.
  - Required: in_ready=4'b0100 in the same cycle. Next cycle out_pkt = 41'h1_A5DEADBEEF, out_src=2, out_valid=1. After acceptance xfer_cnt=1.
- Round-robin wrap:
  - Stimulus: all 4 requesting continuously, out_ready=1, starting from rr_ptr=0.
  - Required: grant order 0,1,2,3,0,1 on consecutive cycles; xfer_cnt=6 after 6 accepts.
- Backpressure:
  - Stimulus: req1 and req3 held, out_ready=0 for 4 cycles after first capture, then out_ready=1.
  - Required: out_pkt/out_src frozen at requester 1 with in_ready=0 while stalled. The drain cycle grants 3 (in_ready=4'b1000).
- Sparse and pointer skip:
  - Stimulus: rr_ptr=2 with only req0 set.
  - Required: requester 0 is granted; rr_ptr becomes 1.
  - Stimulus: FULL, out_ready=1, no requests.
  - Required: state EMPTY, out_valid=0 next cycle.
- Async reset mid-transfer:
  - Stimulus: FULL with out_ready=0; assert rst_n=0 between clock edges.
  - Required: out_valid drops immediately without a clock edge; xfer_cnt=0. After release, pending requests are granted starting from requester 0.
